irq_pending_latch: RTL and testbench

- Front end of the 8-input interrupt path; sits directly upstream of the 8-input priority encoder (in[7:0] -> code[2:0], z).
- Synchronises raw irq lines, rising-edge detects, holds sticky pending bits, applies a mask, and presents a frozen request vector to the encoder.
- The consumer returns the encoder's code as ack_code with an ack strobe; that pending bit is then cleared and the next vector is presented.

---
 rtl/irq_pending_latch.sv | 122 ++++++++++++
 tb/tb_irq_pending_latch.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_latch.sv
// Interrupt front end: sync, edge detect, sticky pending, mask, frozen request to encoder.
// Optional IRQ_OVERFLOW_EN adds ovf/ovf_clr to flag repeat events on already-pending lines.
module irq_pending_latch #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    input  logic       ack,
    input  logic [2:0] ack_code,
    output logic [7:0] req_vec,
    output logic       req_valid,
    output logic [7:0] pending,
    output logic [7:0] mask
`ifdef IRQ_OVERFLOW_EN
    ,
    output logic [7:0] ovf,
    input  logic       ovf_clr
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        CLEAR
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0] hist_q;
    logic [7:0] pend_q, pend_d;
    logic [7:0] mask_q, mask_d;
    logic [7:0] req_q, req_d;
    logic       valid_q, valid_d;
    logic [7:0] rise;
    logic [7:0] clr;
    logic [7:0] ack_oh;

    assign rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign ack_oh = 8'b1 << ack_code;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = valid_q;
        clr     = 8'h00;
        unique case (state_q)
            IDLE: begin
                if (|(pend_q & ~mask_q)) begin
                    state_d = PRESENT;
                    req_d   = pend_q & ~mask_q;
                    valid_d = 1'b1;
                end
            end
            PRESENT: begin
                if (ack) begin
                    clr     = ack_oh & req_q;
                    state_d = CLEAR;
                    req_d   = 8'h00;
                    valid_d = 1'b0;
                end
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 8'h00;
                valid_d = 1'b0;
            end
        endcase
    end

    // A fresh rise outranks a same-cycle clear so no event is lost.
    assign pend_d = (pend_q & ~clr) | rise;
    assign mask_d = mask_we ? mask_wdata : mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            hist_q  <= 8'h00;
            pend_q  <= 8'h00;
            mask_q  <= 8'h00;
            req_q   <= 8'h00;
            valid_q <= 1'b0;
            state_q <= IDLE;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], irq_in};
            hist_q  <= sync_q[SYNC_STAGES-1];
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

`ifdef IRQ_OVERFLOW_EN
    logic [7:0] ovf_q, ovf_d;

    assign ovf_d = (ovf_clr ? 8'h00 : ovf_q) | (rise & pend_q & ~clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 8'h00;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign req_vec   = req_q;
    assign req_valid = valid_q;
    assign pending   = pend_q;
    assign mask      = mask_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch: directed vector table plus randomized run
// against a sample-history reference model.
module tb_irq_pending_latch;

    localparam int S = 2;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_in;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic [2:0] ack_code;
    logic [7:0] req_vec;
    logic       req_valid;
    logic [7:0] pending;
    logic [7:0] mask;
    logic       ovf_clr;
`ifdef IRQ_OVERFLOW_EN
    logic [7:0] ovf;
`endif

    irq_pending_latch #(.SYNC_STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_in),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .ack       (ack),
        .ack_code  (ack_code),
        .req_vec   (req_vec),
        .req_valid (req_valid),
        .pending   (pending),
        .mask      (mask)
`ifdef IRQ_OVERFLOW_EN
        ,
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0] samp[$];
    logic [7:0] m_pend, m_mask, m_req, m_ovf;
    logic       m_valid;
    int         m_gap;

    typedef struct {
        int         grp;
        logic [7:0] irq;
        logic       mwe;
        logic [7:0] mwd;
        logic       ak;
        logic [2:0] code;
        logic       oclr;
        logic       v;
        logic [7:0] req;
        logic [7:0] pend;
        logic [7:0] msk;
        logic [7:0] ov;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input int g, input logic [7:0] irq, input logic mwe,
                       input logic [7:0] mwd, input logic ak, input logic [2:0] code,
                       input logic oclr, input logic v, input logic [7:0] req,
                       input logic [7:0] pend, input logic [7:0] msk,
                       input logic [7:0] ov);
        vec_t r;
        r.grp = g; r.irq = irq; r.mwe = mwe; r.mwd = mwd; r.ak = ak;
        r.code = code; r.oclr = oclr; r.v = v; r.req = req; r.pend = pend;
        r.msk = msk; r.ov = ov;
        tbl.push_back(r);
    endtask

    task automatic model_reset();
        samp.delete();
        for (int i = 0; i < S + 2; i++) samp.push_back(8'h00);
        m_pend = 0; m_mask = 0; m_req = 0; m_ovf = 0;
        m_valid = 0; m_gap = 0;
    endtask

    // An event is seen S edges after the line is first sampled high,
    // provided it was sampled low the edge before that.
    task automatic model_edge();
        logic [7:0] rise, clr, pold, mold;
        int n;
        samp.push_back(irq_in);
        n    = samp.size();
        rise = samp[n-1-S] & ~samp[n-2-S];
        pold = m_pend;
        mold = m_mask;
        clr  = (m_valid && ack) ? ((8'd1 << ack_code) & m_req) : 8'h00;
        m_pend = (pold & ~clr) | rise;
        m_ovf  = (ovf_clr ? 8'h00 : m_ovf) | (rise & pold & ~clr);
        if (mask_we) m_mask = mask_wdata;
        if (m_valid) begin
            if (ack) begin
                m_valid = 0;
                m_req   = 0;
                m_gap   = 1;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if ((pold & ~mold) != 0) begin
            m_valid = 1;
            m_req   = pold & ~mold;
        end
        if (samp.size() > 8) void'(samp.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_idle();
        irq_in = 0; mask_we = 0; mask_wdata = 0;
        ack = 0; ack_code = 0; ovf_clr = 0;
    endtask

    // Outputs must clear with no clock edge in between.
    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        #3;
        model_reset();
        chk("rst_valid", {7'b0, req_valid}, 8'h00);
        chk("rst_req", req_vec, 8'h00);
        chk("rst_pend", pending, 8'h00);
        chk("rst_mask", mask, 8'h00);
`ifdef IRQ_OVERFLOW_EN
        chk("rst_ovf", ovf, 8'h00);
`endif
        rst_n = 1'b1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_valid"}, {7'b0, req_valid}, {7'b0, m_valid});
        chk({tag, "_req"}, req_vec, m_req);
        chk({tag, "_pend"}, pending, m_pend);
        chk({tag, "_mask"}, mask, m_mask);
`ifdef IRQ_OVERFLOW_EN
        chk({tag, "_ovf"}, ovf, m_ovf);
`endif
    endtask

    initial begin
        int last_grp;
        logic [31:0] r;
        rst_n = 1'b0;
        drive_idle();

        // g0: idle after reset, ack ignored outside PRESENT
        for (int i = 0; i < 10; i++)
            add(0, 8'h00, 0, 0, (i % 3 == 0), 3'd3, 0, 0, 0, 0, 0, 0);
        // g1: level-held line 0, one event only
        add(1, 8'h01, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h01, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h01, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0);
        add(1, 8'h01, 0, 0, 0, 0, 0, 1, 8'h01, 8'h01, 0, 0);
        add(1, 8'h01, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h01, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h01, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 8'h01, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        // g2: lines 5 and 1 together
        add(2, 8'h22, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(2, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(2, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h22, 0, 0);
        add(2, 8'h00, 0, 0, 0, 0, 0, 1, 8'h22, 8'h22, 0, 0);
        add(2, 8'h00, 0, 0, 1, 5, 0, 0, 8'h00, 8'h02, 0, 0);
        add(2, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0);
        add(2, 8'h00, 0, 0, 0, 0, 0, 1, 8'h02, 8'h02, 0, 0);
        add(2, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        add(2, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(2, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        // g3: request frozen while line 7 arrives
        add(3, 8'h04, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(3, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(3, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 0);
        add(3, 8'h00, 0, 0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 0);
        add(3, 8'h80, 0, 0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 0);
        add(3, 8'h00, 0, 0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 0);
        add(3, 8'h00, 0, 0, 0, 0, 0, 1, 8'h04, 8'h84, 0, 0);
        add(3, 8'h00, 0, 0, 1, 2, 0, 0, 8'h00, 8'h80, 0, 0);
        add(3, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h80, 0, 0);
        add(3, 8'h00, 0, 0, 0, 0, 0, 1, 8'h80, 8'h80, 0, 0);
        add(3, 8'h00, 0, 0, 1, 7, 0, 0, 8'h00, 8'h00, 0, 0);
        // g4: masked then unmasked
        add(4, 8'h08, 1, 8'hFF, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0);
        add(4, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 0);
        add(4, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 8'hFF, 0);
        add(4, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h08, 8'hFF, 0);
        add(4, 8'h00, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h08, 8'h00, 0);
        add(4, 8'h00, 0, 0, 0, 0, 0, 1, 8'h08, 8'h08, 8'h00, 0);
        add(4, 8'h00, 0, 0, 1, 3, 0, 0, 8'h00, 8'h00, 8'h00, 0);
        // g5: set beats clear, then overflow and its clear
        add(5, 8'h04, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(5, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        add(5, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 0);
        add(5, 8'h00, 0, 0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 0);
        add(5, 8'h04, 0, 0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 0);
        add(5, 8'h00, 0, 0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 0);
        add(5, 8'h00, 0, 0, 1, 2, 0, 0, 8'h00, 8'h04, 0, 8'h00);
        add(5, 8'h00, 0, 0, 0, 0, 0, 0, 8'h00, 8'h04, 0, 8'h00);
        add(5, 8'h00, 0, 0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 8'h00);
        add(5, 8'h04, 0, 0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 8'h00);
        add(5, 8'h00, 0, 0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 8'h00);
        add(5, 8'h00, 0, 0, 0, 0, 0, 1, 8'h04, 8'h04, 0, 8'h04);
        add(5, 8'h00, 0, 0, 0, 0, 1, 1, 8'h04, 8'h04, 0, 8'h00);

        last_grp = -1;
        foreach (tbl[k]) begin
            if (tbl[k].grp != last_grp) begin
                do_reset();
                last_grp = tbl[k].grp;
            end
            irq_in     = tbl[k].irq;
            mask_we    = tbl[k].mwe;
            mask_wdata = tbl[k].mwd;
            ack        = tbl[k].ak;
            ack_code   = tbl[k].code;
            ovf_clr    = tbl[k].oclr;
            step();
            chk($sformatf("g%0d_r%0d_valid", tbl[k].grp, k),
                {7'b0, req_valid}, {7'b0, tbl[k].v});
            chk($sformatf("g%0d_r%0d_req", tbl[k].grp, k), req_vec, tbl[k].req);
            chk($sformatf("g%0d_r%0d_pend", tbl[k].grp, k), pending, tbl[k].pend);
            chk($sformatf("g%0d_r%0d_mask", tbl[k].grp, k), mask, tbl[k].msk);
`ifdef IRQ_OVERFLOW_EN
            chk($sformatf("g%0d_r%0d_ovf", tbl[k].grp, k), ovf, tbl[k].ov);
`endif
        end

        // Group 5 ends in PRESENT; this reset checks the async drop.
        do_reset();

        for (int c = 0; c < 3000; c++) begin
            r          = $urandom;
            irq_in     = irq_in ^ (r[7:0] & r[15:8] & r[23:16]);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 8'($urandom) & 8'($urandom);
            ack        = m_valid ? ($urandom_range(0, 2) == 0)
                                 : ($urandom_range(0, 1) == 0);
            ack_code   = 3'($urandom);
            ovf_clr    = ($urandom_range(0, 31) == 0);
            step();
            cmp_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
